// File: rtl/dly_line_arb.sv
// Round-robin arbitrated, channel-tagged delay line: NUM_CH producers share one LEN-deep FIFO
// whose output is held back until LEN words are stored (or a flush), then drains to empty.
module dly_line_arb #(
  parameter int NUM_CH = 3,
  parameter int LEN = 4,
  parameter int W_DIN = 16,
  localparam int W_CH = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*W_DIN-1:0] din_data,
  input  logic [NUM_CH-1:0]       din_valid,
  output logic [NUM_CH-1:0]       din_ready,
  input  logic                    flush,
  output logic [W_CH+W_DIN-1:0]   dout_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [$clog2(LEN+1)-1:0] occupancy,
  output logic                    primed
);

  localparam int OW = $clog2(LEN + 1);
  localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int W_E = W_CH + W_DIN;
  localparam logic [OW-1:0] LEN_C = OW'(LEN);

  // Valid/ready: a transfer happens on a channel in exactly the cycle where its valid and
  // ready are both high; valid never waits on ready, and ready is offered only to the grant.
  typedef enum logic {FILL, RUN} state_t;

  state_t          state, state_next;
  logic [W_E-1:0]  mem [LEN];
  logic [PW-1:0]   head, tail;
  logic [W_CH-1:0] rr_ptr, grant, cand;
  logic [OW-1:0]   occ_next;
  logic            any_valid, found, pop, can_push, accept;
  int              scan_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  // Rotating priority scan starting at rr_ptr; depends only on din_valid and rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      cand = W_CH'(scan_idx);
      if (!found && din_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign any_valid  = |din_valid;
  assign dout_valid = (state == RUN) && (occupancy != '0);
  assign dout_data  = mem[head];
  assign pop        = dout_valid && dout_ready;
  assign can_push   = (occupancy < LEN_C) || pop;
  assign accept     = rst && any_valid && can_push;
  assign primed     = (state == RUN);

  always_comb begin
    din_ready = '0;
    if (rst && any_valid) din_ready[grant] = can_push;
  end

  always_comb begin
    occ_next = occupancy;
    if (accept && !pop) occ_next = occupancy + 1'b1;
    else if (!accept && pop) occ_next = occupancy - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: if ((occ_next == LEN_C) || (flush && (occupancy != '0))) state_next = RUN;
      RUN:  if (occ_next == '0) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      occupancy <= '0;
      rr_ptr    <= '0;
      head      <= '0;
      tail      <= '0;
      for (int i = 0; i < LEN; i++) mem[i] <= '0;
    end else begin
      state     <= state_next;
      occupancy <= occ_next;
      if (pop) head <= ptr_inc(head);
      if (accept) begin
        mem[tail] <= {grant, din_data[int'(grant)*W_DIN +: W_DIN]};
        tail      <= ptr_inc(tail);
        rr_ptr    <= (grant == W_CH'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: doc/dly_line_arb.md
Name: dly_line_arb

Overview:
- Shares one LEN-deep delay buffer between NUM_CH dti-style producers.
- A round-robin arbiter picks one producer per cycle and tags each stored word with its channel id.
- A fill/run sequencer holds the output back until the buffer has primed with LEN words, then streams words out. It keeps streaming until the buffer is fully empty.
- Sits upstream of shared consumers that need a fixed LEN-item skew between the accepted and released streams.

Parameters:
- NUM_CH, 3: number of requesting channels (>=2).
- LEN, 4: delay depth in words (>=1).
- W_DIN, 16: data width per channel.
- W_CH, $clog2(NUM_CH): channel tag width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- din_data  in  NUM_CH*W_DIN  channel i data at bits [i*W_DIN +: W_DIN].
- din_valid  in  NUM_CH  per-channel valid.
- din_ready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- flush  in  1  level request to release a partially filled buffer.
- dout_data  out  W_CH+W_DIN  {channel tag, data} of the buffer head.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.
- occupancy  out  $clog2(LEN+1)  stored word count.
- primed  out  1  high while in RUN.

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - state=FILL, occupancy=0, rr_ptr=0.
  - dout_valid=0, dout_data=0, din_ready=0, primed=0.
  - Storage contents are cleared to 0.
- Reset mid-operation discards all stored words; no output handshake may occur in the reset cycle.
- Storage is a circular FIFO of LEN entries. Each entry is {tag, data}.
- Arbitration:
  - grant = the first channel with din_valid=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - grant is combinational from din_valid and rr_ptr only; it never depends on din_ready or dout_ready.
- accept = can_push && any din_valid, where can_push = (occupancy<LEN) || pop.
  - din_ready[grant]=can_push; all other din_ready bits are 0.
  - When no channel is valid, din_ready is all 0.
- On an input handshake:
  - store {grant, din_data[grant]} at the tail.
  - rr_ptr <= (grant+1) mod NUM_CH.
  - rr_ptr does not change on cycles with no handshake.
- pop = dout_valid && dout_ready.
- dout_valid = (state==RUN) && (occupancy>0). dout_data always shows the head entry.
- Simultaneous push and pop: occupancy is unchanged and FIFO order is preserved. At occupancy==LEN, the popped slot is refilled in the same cycle. This gives zero-bubble streaming at full occupancy.
- Latency: a word accepted into an empty buffer appears on dout no earlier than the cycle after the LEN-th word is accepted.
- State machine:
  - FILL -> RUN when occupancy would become LEN, or when flush=1 && occupancy>0. The transition takes effect on the next cycle.
  - RUN -> FILL when occupancy would become 0, i.e. the last word pops with no push in the same cycle.
  - In RUN, pushes continue normally. Output never pauses while any word remains stored.
- flush has no effect in RUN or with occupancy==0.
- primed = (state==RUN), registered.
- occupancy saturation: the counter never exceeds LEN and never drops below 0. The push and pop qualifiers guarantee this by construction.
- Channel tag is the binary index of the granted channel, zero-extended to W_CH.

Test Plan:
- Reset/idle:
  - Stimulus: rst low for 3 cycles with din_valid=3'b111; release rst.
  - Required: during reset, all outputs are 0.
  - Required: after reset, ch0 is granted first and occupancy increments from 0.
- Priming delay (LEN=4, ch0 only):
  - Stimulus: ch0 offers 0x0001..0x0006, dout_ready=1.
  - Required: dout_valid stays 0 until 4 words are accepted, then goes high the next cycle with {0,0x0001}.
  - Required: words 0x0001..0x0006 emerge in order; occupancy holds at 4 while streaming.
- Round-robin fairness:
  - Stimulus: all three channels are valid continuously.
  - Required: grant order is 0,1,2,0,1,2.
  - Required: output tags follow the same sequence; no channel is granted twice before the others are granted once.
- Backpressure at full:
  - Stimulus: buffer primed at occupancy=4, dout_ready=0 for 5 cycles with inputs valid.
  - Required: din_ready is all 0, occupancy stays 4, dout_data is stable.
  - Required: when dout_ready returns to 1, push and pop occur in the same cycle.
- Flush drain:
  - Stimulus: two words (ch1 0x00AA, ch2 0x00BB) stored in FILL, then flush pulsed for 1 cycle, dout_ready=1.
  - Required: state goes to RUN; {1,0x00AA} then {2,0x00BB} are output.
  - Required: after the last pop, state returns to FILL, primed=0, dout_valid=0.
- Reset mid-stream:
  - Stimulus: assert rst while in RUN with occupancy=3.
  - Required: dout_valid drops asynchronously; occupancy=0 and state=FILL after release.
  - Required: none of the old words ever reappear.
